fp_mult_responder: RTL and testbench
====================================

Name: fp_mult_responder

Overview:
- Responder end of the shared-arithmetic start/operand/result_ready handshake that the evaluator FSMs (angle combination, term accumulator) drive as initiators.
- Accepts one IEEE-754 single-precision multiply request, computes it over a fixed multi-cycle FSM, and returns the product with a one-cycle ready pulse.
- Sits behind the evaluator's mult_operand_a/mult_operand_b/mult_start outputs and feeds its mult_result/mult_result_ready inputs.

Parameters:
- EXP_LEN, 8, exponent field width
- MANTISSA_LEN, 23, stored fraction width (hidden bit excluded)
- DATA_WIDTH, 32, word width; must equal 1+EXP_LEN+MANTISSA_LEN

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-low reset
- mult_start  in  1  request; sampled only in IDLE
- mult_operand_a  in  DATA_WIDTH  multiplicand; latched with accepted start
- mult_operand_b  in  DATA_WIDTH  multiplier; latched with accepted start
- mult_result  out  DATA_WIDTH  product; valid while mult_result_ready=1, held until the next completion
- mult_result_ready  out  1  one-cycle completion pulse
- mult_busy  out  1  high from acceptance until the DONE cycle inclusive

Behaviour:
- Reset (reset=0 at a clock edge): state=IDLE; mult_result=0, mult_result_ready=0, mult_busy=0.
  - Takes precedence over everything, including mid-operation; an aborted operation never pulses ready.
- States: IDLE -> MULT -> NORM -> ROUND -> DONE -> IDLE.
- IDLE
  - mult_start=1 latches both operands, unpacks sign/exp/fraction, classifies specials, and goes to MULT.
  - mult_start=0 stays in IDLE.
- MULT
  - sign = sa^sb.
  - Exponent sum is computed as a signed EXP_LEN+2 bit value: ea+eb-127.
  - Registers the 48-bit product of the 24-bit significands (hidden bit 1).
- NORM
  - If product bit47=1: shift right 1 and exponent+1.
  - Extract a 24-bit significand plus guard bit and sticky bit (OR of the remaining bits).
- ROUND
  - Round to nearest, ties to even.
  - Mantissa carry-out renormalises: exponent+1, significand=1.0.
  - Then apply range checks:
    - exponent >= 255: signed infinity.
    - exponent <= 0: signed zero (no subnormal output).
- DONE
  - mult_result takes the final value and mult_result_ready=1 for exactly this cycle; then IDLE.
  - mult_start is ignored in DONE.
  - A start still held high in the following IDLE cycle begins a new operation, so initiators must drop start once ready is seen.
- Latency: start sampled at edge T gives mult_result_ready=1 in the cycle after edge T+4. Throughput is one result per 5 cycles.
- Special-case handling is resolved at acceptance and carried through the pipeline; arithmetic states still elapse, so latency is constant.
  - Exponent field 0: operand treated as zero (flush-to-zero, fraction ignored).
  - Either operand NaN (exp=255, frac!=0): result is canonical NaN 0x7FC00000.
  - Inf x zero: 0x7FC00000.
  - Inf x finite nonzero, or inf x inf: infinity with sign sa^sb.
  - Zero x finite: zero with sign sa^sb.
- mult_start while busy has no effect. Operand changes after acceptance have no effect.

Decomposition:
- fp_pkg (shared package):
  - EXP_LEN/MANTISSA_LEN defaults and BIAS=127.
  - FP_QNAN=0x7FC00000, FP_POS_INF=0x7F800000.
  - fp_class_t enum {ZERO, NORMAL, INF, NAN}.
  - fp_mult_state_t enum for the five states.
- Sub-module fp_classify: combinational unpack plus class detect; instantiated twice, once per operand.
- The FSM, multiply, normalise and round live in fp_mult_responder.

Test Plan:
- 0x40000000 x 0x40400000 (2.0 x 3.0), start pulsed at edge T -> ready exactly one cycle after edge T+4, result 0x40C00000, busy high 5 cycles.
- 0x3FC00000 x 0x3FC00000 (1.5 x 1.5) -> 0x40100000 (normalise path).
- 0xC0000000 x 0x40400000 -> 0xC0C00000.
- 0x3F800001 x 0x3F800001 -> 0x3F800002 (round to nearest even).
- Special cases:
  - 0x7F800000 x 0x00000000 -> 0x7FC00000.
  - 0x7F000000 x 0x7F000000 -> 0x7F800000 (overflow).
  - 0x00800000 x 0x00800000 -> 0x00000000 (underflow).
  - 0x00000001 x 0x3F800000 -> 0x00000000 (FTZ input).
- Protocol and reset:
  - Start held high for 8 cycles -> two results, with acceptances 5 cycles apart.
  - New operands applied while busy -> first result unchanged.
  - reset=0 during NORM -> no ready pulse, result 0; the next request completes normally.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared single-precision definitions used by the multiply responder and its
// operand classifier.
package fp_pkg;

    localparam int EXP_LEN_DEF      = 8;
    localparam int MANTISSA_LEN_DEF = 23;
    localparam int BIAS             = 127;

    localparam logic [31:0] FP_QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORMAL,
        CLS_INF,
        CLS_NAN
    } fp_class_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_NORM,
        ST_ROUND,
        ST_DONE
    } fp_mult_state_t;

endpackage

// File: rtl/fp_classify.sv
// Unpacks one IEEE-754 word into sign, exponent and significand with the hidden
// bit restored, and classifies it. A zero exponent field flushes to zero.
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_LEN      = EXP_LEN_DEF,
    parameter int MANTISSA_LEN = MANTISSA_LEN_DEF,
    parameter int DATA_WIDTH   = 1 + EXP_LEN + MANTISSA_LEN
) (
    input  logic [DATA_WIDTH-1:0]  op_i,
    output logic                   sign_o,
    output logic [EXP_LEN-1:0]     exp_o,
    output logic [MANTISSA_LEN:0]  sig_o,
    output fp_class_t              class_o
);

    logic [MANTISSA_LEN-1:0] frac;

    assign sign_o = op_i[DATA_WIDTH-1];
    assign exp_o  = op_i[DATA_WIDTH-2 -: EXP_LEN];
    assign frac   = op_i[MANTISSA_LEN-1:0];
    assign sig_o  = {1'b1, frac};

    always_comb begin
        class_o = CLS_NORMAL;
        if (exp_o == '0) begin
            class_o = CLS_ZERO;
        end else if (exp_o == '1) begin
            class_o = (frac != '0) ? CLS_NAN : CLS_INF;
        end
    end

endmodule

// File: rtl/fp_mult_responder.sv
// Multi-cycle single-precision multiplier answering a start/result_ready
// handshake; fixed five-cycle turnaround including the idle cycle.
module fp_mult_responder
    import fp_pkg::*;
#(
    parameter int EXP_LEN      = 8,
    parameter int MANTISSA_LEN = 23,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  mult_start,
    input  logic [DATA_WIDTH-1:0] mult_operand_a,
    input  logic [DATA_WIDTH-1:0] mult_operand_b,
    output logic [DATA_WIDTH-1:0] mult_result,
    output logic                  mult_result_ready,
    output logic                  mult_busy
);

    localparam int SIG_W    = MANTISSA_LEN + 1;
    localparam int PROD_W   = 2 * SIG_W;
    localparam int EXP_W    = EXP_LEN + 2;
    localparam int EXP_BIAS = (1 << (EXP_LEN - 1)) - 1;
    localparam int EXP_MAX  = (1 << EXP_LEN) - 1;

    localparam logic signed [EXP_W-1:0] BIAS_S    = EXP_W'(EXP_BIAS);
    localparam logic signed [EXP_W-1:0] EXP_MAX_S = EXP_W'(EXP_MAX);
    localparam logic signed [EXP_W-1:0] EXP_ONE_S = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_ZERO_S = '0;

    localparam logic [DATA_WIDTH-1:0] QNAN_W =
        {1'b0, {EXP_LEN{1'b1}}, 1'b1, {(MANTISSA_LEN-1){1'b0}}};

    // Round to nearest, ties to even; the extra top bit is the mantissa carry.
    function automatic logic [SIG_W:0] round_rne(input logic [SIG_W-1:0] sig,
                                                 input logic g, input logic s);
        return {1'b0, sig} + (SIG_W+1)'(g & (s | sig[0]));
    endfunction

    // Saturate to infinity on overflow, flush to signed zero on underflow.
    function automatic logic [DATA_WIDTH-1:0] pack_range(input logic sign,
                                                         input logic signed [EXP_W-1:0] e,
                                                         input logic [SIG_W-1:0] sig);
        if (e >= EXP_MAX_S)
            return {sign, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
        else if (e <= EXP_ZERO_S)
            return {sign, {(DATA_WIDTH-1){1'b0}}};
        else
            return {sign, e[EXP_LEN-1:0], sig[MANTISSA_LEN-1:0]};
    endfunction

    fp_mult_state_t state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;

    logic                     sign_q;
    logic [EXP_LEN-1:0]       exp_a_q, exp_b_q;
    logic [SIG_W-1:0]         sig_a_q, sig_b_q;
    logic                     special_q;
    logic [DATA_WIDTH-1:0]    special_val_q;
    logic [PROD_W-1:0]        prod_q;
    logic signed [EXP_W-1:0]  exp_q;
    logic [SIG_W-1:0]         sig_q;
    logic                     guard_q, sticky_q;
    logic [DATA_WIDTH-1:0]    res_q;

    logic                  sign_a, sign_b, sign_ab;
    logic [EXP_LEN-1:0]    exp_a, exp_b;
    logic [SIG_W-1:0]      sig_a, sig_b;
    fp_class_t             cls_a, cls_b;
    logic                  spec_hit;
    logic [DATA_WIDTH-1:0] spec_val;

    logic [SIG_W-1:0]         norm_sig;
    logic                     norm_guard, norm_sticky;
    logic signed [EXP_W-1:0]  norm_exp;
    logic [SIG_W:0]           rnd_sum;
    logic [SIG_W-1:0]         rnd_sig;
    logic signed [EXP_W-1:0]  rnd_exp;
    logic [DATA_WIDTH-1:0]    final_val;

    fp_classify #(.EXP_LEN(EXP_LEN), .MANTISSA_LEN(MANTISSA_LEN), .DATA_WIDTH(DATA_WIDTH)) u_cls_a (
        .op_i    (mult_operand_a),
        .sign_o  (sign_a),
        .exp_o   (exp_a),
        .sig_o   (sig_a),
        .class_o (cls_a)
    );

    fp_classify #(.EXP_LEN(EXP_LEN), .MANTISSA_LEN(MANTISSA_LEN), .DATA_WIDTH(DATA_WIDTH)) u_cls_b (
        .op_i    (mult_operand_b),
        .sign_o  (sign_b),
        .exp_o   (exp_b),
        .sig_o   (sig_b),
        .class_o (cls_b)
    );

    assign sign_ab = sign_a ^ sign_b;

    // Specials are decided at acceptance; the arithmetic states still run so latency is fixed.
    always_comb begin
        spec_hit = 1'b1;
        spec_val = QNAN_W;
        if (cls_a == CLS_NAN || cls_b == CLS_NAN) begin
            spec_val = QNAN_W;
        end else if ((cls_a == CLS_INF && cls_b == CLS_ZERO) ||
                     (cls_a == CLS_ZERO && cls_b == CLS_INF)) begin
            spec_val = QNAN_W;
        end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
            spec_val = {sign_ab, {EXP_LEN{1'b1}}, {MANTISSA_LEN{1'b0}}};
        end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
            spec_val = {sign_ab, {(DATA_WIDTH-1){1'b0}}};
        end else begin
            spec_hit = 1'b0;
            spec_val = '0;
        end
    end

    always_comb begin
        if (prod_q[PROD_W-1]) begin
            norm_sig    = prod_q[PROD_W-1 -: SIG_W];
            norm_guard  = prod_q[PROD_W-1-SIG_W];
            norm_sticky = |prod_q[PROD_W-2-SIG_W:0];
            norm_exp    = exp_q + EXP_ONE_S;
        end else begin
            norm_sig    = prod_q[PROD_W-2 -: SIG_W];
            norm_guard  = prod_q[PROD_W-2-SIG_W];
            norm_sticky = |prod_q[PROD_W-3-SIG_W:0];
            norm_exp    = exp_q;
        end
    end

    always_comb begin
        rnd_sum = round_rne(sig_q, guard_q, sticky_q);
        rnd_sig = rnd_sum[SIG_W-1:0];
        rnd_exp = exp_q;
        if (rnd_sum[SIG_W]) begin
            rnd_sig = {1'b1, {MANTISSA_LEN{1'b0}}};
            rnd_exp = exp_q + EXP_ONE_S;
        end
        final_val = special_q ? special_val_q : pack_range(sign_q, rnd_exp, rnd_sig);
    end

    // Datapath registers carry no reset; the control state gates their use.
    always_ff @(posedge clock) begin
        case (state_q)
            ST_IDLE: begin
                if (mult_start) begin
                    sign_q        <= sign_ab;
                    exp_a_q       <= exp_a;
                    exp_b_q       <= exp_b;
                    sig_a_q       <= sig_a;
                    sig_b_q       <= sig_b;
                    special_q     <= spec_hit;
                    special_val_q <= spec_val;
                end
            end
            ST_MULT: begin
                prod_q <= PROD_W'(sig_a_q) * PROD_W'(sig_b_q);
                exp_q  <= $signed({2'b00, exp_a_q}) + $signed({2'b00, exp_b_q}) - BIAS_S;
            end
            ST_NORM: begin
                sig_q    <= norm_sig;
                guard_q  <= norm_guard;
                sticky_q <= norm_sticky;
                exp_q    <= norm_exp;
            end
            ST_ROUND: begin
                res_q <= final_val;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        ready_d  = 1'b0;
        case (state_q)
            ST_IDLE:  if (mult_start) state_d = ST_MULT;
            ST_MULT:  state_d = ST_NORM;
            ST_NORM:  state_d = ST_ROUND;
            ST_ROUND: state_d = ST_DONE;
            ST_DONE: begin
                result_d = res_q;
                ready_d  = 1'b1;
                state_d  = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE) || ready_d;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
        end
    end

    assign mult_result       = result_q;
    assign mult_result_ready = ready_q;
    assign mult_busy         = busy_q;

endmodule

// File: tb/tb_fp_mult_responder.sv
// Directed bench for fp_mult_responder: arithmetic, specials, handshake timing
// and reset behaviour against hand-computed products.
module tb_fp_mult_responder;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] op_a  = '0;
    logic [31:0] op_b  = '0;
    logic [31:0] result;
    logic        ready;
    logic        busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    fp_mult_responder dut (
        .clock             (clock),
        .reset             (reset),
        .mult_start        (start),
        .mult_operand_a    (op_a),
        .mult_operand_b    (op_b),
        .mult_result       (result),
        .mult_result_ready (ready),
        .mult_busy         (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Pulses start for one edge and watches 10 cycles; lat is the cycle index of ready (0 = never).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat, output int busy_cyc);
        @(negedge clock);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        lat      = 0;
        busy_cyc = 0;
        res      = 'x;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clock);
            if (busy) busy_cyc++;
            if (ready && lat == 0) begin
                lat = i;
                res = result;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        vec_cnt++;
        if (ready !== 1'b0) begin err_cnt++; $display("FAIL reset_ready got %b want 0", ready); end
        vec_cnt++;
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got %b want 0", busy); end
        vec_cnt++;
        if (result !== 32'h0) begin err_cnt++; $display("FAIL reset_result got %h want 00000000", result); end
        reset = 1'b1;
    endtask

    task automatic test_latency();
        logic [31:0] res;
        int lat, bc;
        run_op(32'h4000_0000, 32'h4040_0000, res, lat, bc);
        vec_cnt++;
        if (lat !== 5) begin err_cnt++; $display("FAIL latency got %0d want 5", lat); end
        vec_cnt++;
        if (bc !== 5) begin err_cnt++; $display("FAIL busy_cycles got %0d want 5", bc); end
        vec_cnt++;
        if (res !== 32'h40C0_0000) begin err_cnt++; $display("FAIL mul_2x3 got %h want 40c00000", res); end
    endtask

    logic [31:0] ar_a [6] = '{32'h3FC0_0000, 32'hC000_0000, 32'h3F80_0001, 32'h3F80_0001, 32'h3FFF_FFFF, 32'h4040_0000};
    logic [31:0] ar_b [6] = '{32'h3FC0_0000, 32'h4040_0000, 32'h3F80_0001, 32'h3FC0_0000, 32'h3F80_0001, 32'hC000_0000};
    logic [31:0] ar_e [6] = '{32'h4010_0000, 32'hC0C0_0000, 32'h3F80_0002, 32'h3FC0_0002, 32'h4000_0000, 32'hC0C0_0000};

    task automatic test_arith();
        logic [31:0] res;
        int lat, bc;
        for (int i = 0; i < 6; i++) begin
            run_op(ar_a[i], ar_b[i], res, lat, bc);
            vec_cnt++;
            if (res !== ar_e[i]) begin
                err_cnt++;
                $display("FAIL arith[%0d] %h x %h got %h want %h (lat %0d)", i, ar_a[i], ar_b[i], res, ar_e[i], lat);
            end
        end
    endtask

    logic [31:0] sp_a [7] = '{32'h7F80_0000, 32'h7F00_0000, 32'h0080_0000, 32'h0000_0001, 32'h7FC0_0001, 32'h7F80_0000, 32'h8000_0000};
    logic [31:0] sp_b [7] = '{32'h0000_0000, 32'h7F00_0000, 32'h0080_0000, 32'h3F80_0000, 32'h3F80_0000, 32'hC000_0000, 32'h4040_0000};
    logic [31:0] sp_e [7] = '{32'h7FC0_0000, 32'h7F80_0000, 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 32'hFF80_0000, 32'h8000_0000};

    task automatic test_special();
        logic [31:0] res;
        int lat, bc;
        for (int i = 0; i < 7; i++) begin
            run_op(sp_a[i], sp_b[i], res, lat, bc);
            vec_cnt++;
            if (res !== sp_e[i] || lat != 5) begin
                err_cnt++;
                $display("FAIL special[%0d] %h x %h got %h lat %0d want %h lat 5", i, sp_a[i], sp_b[i], res, lat, sp_e[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n_rdy = 0;
        int first = 0, second = 0;
        logic [31:0] r1 = 'x, r2 = 'x;
        @(negedge clock);
        op_a  = 32'h3FC0_0000;
        op_b  = 32'h3FC0_0000;
        start = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clock);
            #1 if (i == 8) start = 1'b0;
            @(negedge clock);
            if (ready) begin
                n_rdy++;
                if (n_rdy == 1) begin first = i; r1 = result; end
                if (n_rdy == 2) begin second = i; r2 = result; end
            end
        end
        vec_cnt++;
        if (n_rdy !== 2) begin err_cnt++; $display("FAIL b2b_count got %0d want 2", n_rdy); end
        vec_cnt++;
        if (second - first !== 5) begin err_cnt++; $display("FAIL b2b_spacing got %0d want 5", second - first); end
        vec_cnt++;
        if (r1 !== 32'h4010_0000) begin err_cnt++; $display("FAIL b2b_first got %h want 40100000", r1); end
        vec_cnt++;
        if (r2 !== 32'h4010_0000) begin err_cnt++; $display("FAIL b2b_second got %h want 40100000", r2); end
    endtask

    task automatic test_operand_change();
        int n_rdy = 0;
        logic [31:0] r1 = 'x;
        @(negedge clock);
        op_a  = 32'h4000_0000;
        op_b  = 32'h4040_0000;
        start = 1'b1;
        @(posedge clock);
        #1;
        op_a  = 32'h7FC0_0001;
        op_b  = 32'h0000_0000;
        for (int i = 1; i <= 12; i++) begin
            if (i == 4) start = 1'b0;
            @(negedge clock);
            if (ready) begin
                n_rdy++;
                if (n_rdy == 1) r1 = result;
            end
            @(posedge clock);
            #1;
        end
        vec_cnt++;
        if (r1 !== 32'h40C0_0000) begin err_cnt++; $display("FAIL opchange_result got %h want 40c00000", r1); end
        vec_cnt++;
        if (n_rdy !== 1) begin err_cnt++; $display("FAIL opchange_pulses got %0d want 1", n_rdy); end
    endtask

    task automatic test_reset_mid();
        int n_rdy = 0;
        logic [31:0] res;
        int lat, bc;
        @(negedge clock);
        op_a  = 32'h4000_0000;
        op_b  = 32'h4040_0000;
        start = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1 reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (ready) n_rdy++;
        end
        vec_cnt++;
        if (n_rdy !== 0) begin err_cnt++; $display("FAIL abort_pulses got %0d want 0", n_rdy); end
        vec_cnt++;
        if (result !== 32'h0) begin err_cnt++; $display("FAIL abort_result got %h want 00000000", result); end
        vec_cnt++;
        if (busy !== 1'b0) begin err_cnt++; $display("FAIL abort_busy got %b want 0", busy); end
        run_op(32'h3FC0_0000, 32'h3FC0_0000, res, lat, bc);
        vec_cnt++;
        if (res !== 32'h4010_0000 || lat != 5) begin
            err_cnt++;
            $display("FAIL after_abort got %h lat %0d want 40100000 lat 5", res, lat);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arith();
        test_special();
        test_back_to_back();
        test_operand_change();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
